// File: rtl/wu_jitter_logger.sv
// wu_jitter_logger: per-event FIFO of wake-up jitter samples, drained one entry per host toggle.
// Optional macro WU_LOG_TIMESTAMP_EN stores a 32-bit free-running cycle stamp with each sample.
module wu_jitter_logger #(
  parameter int DEPTH_LOG2 = 8,
  parameter int JW         = 32
) (
  input  logic                  clki,
  input  logic                  reset,
  input  logic [19:0]           tp_count,
  input  logic [JW-1:0]         jitter_in,
  input  logic                  rd_toggle,
  output logic [JW-1:0]         rd_data,
  output logic                  rd_valid,
  output logic [31:0]           rd_stamp,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic [15:0]           overflow_count
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
`ifdef WU_LOG_TIMESTAMP_EN
  localparam int MW = JW + 32;
`else
  localparam int MW = JW;
`endif
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = DEPTH[DEPTH_LOG2:0];

  logic [MW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [15:0]           ovf_q, ovf_d;
  logic [19:0]           tp_prev_q, tp_prev_d;
  logic                  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [JW-1:0]         rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_w, empty_w;
  logic                  push_req, pop_req, push_acc, pop_acc;
  logic [MW-1:0]         wr_word, head_word;

  // Push/pop contract: a push is any rise of tp_count and is never back-pressured;
  // a pop is any level change of rd_toggle. A pop is served before a push on the
  // same edge, so a full FIFO can accept a push when a pop frees the head slot.
  always_comb begin
    full_w     = (level_q == LEVEL_FULL);
    empty_w    = (level_q == '0);
    push_req   = (tp_count > tp_prev_q);
    pop_req    = (s2_q != s3_q);
    pop_acc    = pop_req && !empty_w;
    push_acc   = push_req && (!full_w || pop_acc);
    head_word  = mem[rd_ptr_q];
    tp_prev_d  = tp_count;
    s1_d       = rd_toggle;
    s2_d       = s1_q;
    s3_d       = s2_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    level_d    = level_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push_req && !push_acc && ovf_q != 16'hFFFF) ovf_d = ovf_q + 1'b1;
    if (pop_req) begin
      rd_valid_d = pop_acc;
      if (pop_acc) begin
        rd_data_d = head_word[JW-1:0];
        rd_ptr_d  = rd_ptr_q + 1'b1;
      end
    end
    case ({push_acc, pop_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      // Reload from live inputs so leaving reset never looks like an event.
      tp_prev_q  <= tp_count;
      s1_q       <= rd_toggle;
      s2_q       <= rd_toggle;
      s3_q       <= rd_toggle;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      tp_prev_q  <= tp_prev_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
    end
  end

  always_ff @(posedge clki) begin
    if (push_acc && !reset) mem[wr_ptr_q] <= wr_word;
  end

`ifdef WU_LOG_TIMESTAMP_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] rd_stamp_q, rd_stamp_d;

  always_comb begin
    cyc_d      = cyc_q + 1'b1;
    rd_stamp_d = pop_acc ? head_word[MW-1:JW] : rd_stamp_q;
    wr_word    = {cyc_q, jitter_in};
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      cyc_q      <= '0;
      rd_stamp_q <= '0;
    end else begin
      cyc_q      <= cyc_d;
      rd_stamp_q <= rd_stamp_d;
    end
  end

  assign rd_stamp = rd_stamp_q;
`else
  always_comb wr_word = jitter_in;
  assign rd_stamp = '0;
`endif

  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign level          = level_q;
  assign empty          = empty_w;
  assign full           = full_w;
  assign overflow_count = ovf_q;
endmodule

// File: doc/wu_jitter_logger.md
# wu_jitter_logger

Per-event buffer for wake-up jitter samples. It sits directly downstream of the wake-up counter. On every increment of the true-positive count it captures the current 32-bit wake-up jitter value into an on-chip FIFO. The host then drains the FIFO one entry per toggle of a wire-in bit, which replaces single-value jitter readout with a full per-trigger record for host-side statistics.

## Interface
Parameters:
- DEPTH_LOG2, 8: FIFO depth is 2^DEPTH_LOG2 entries (256).
- JW, 32: jitter sample width.

Ports:
- clki, input, 1: system clock (100 MHz); all logic on its rising edge.
- reset, input, 1: synchronous, active-high; clears all state.
- tp_count, input, 20: true-positive count from the wake-up counter, synchronous to clki.
- jitter_in, input, JW: wake-up jitter from the wake-up counter, valid whenever tp_count changes.
- rd_toggle, input, 1: host pop request; each level change requests one pop. It is quasi-static and is synchronised internally.
- rd_data, output, JW: last popped sample, held until the next successful pop. Reset 0.
- rd_valid, output, 1: 1 if the last pop request returned data; 0 if it hit an empty FIFO. Reset 0.
- rd_stamp, output, 32: timestamp of the last popped sample (see Configuration). Reset 0.
- level, output, DEPTH_LOG2+1: current occupancy, 0 to 2^DEPTH_LOG2. Reset 0.
- empty, output, 1: level == 0. Reset 1.
- full, output, 1: level == 2^DEPTH_LOG2. Reset 0.
- overflow_count, output, 16: number of dropped samples, saturating at 16'hFFFF. Reset 0.

## Operation
- Push detect:
  - tp_prev (20 bit) registers tp_count every cycle.
  - A push is requested when tp_count > tp_prev (unsigned).
  - A jump of more than 1 in a single cycle still produces exactly one push.
  - tp_count < tp_prev (upstream counter reset) produces no push; tp_prev simply reloads.
- Push:
  - jitter_in is written at the write pointer on the same edge the push is detected.
  - The write pointer increments modulo 2^DEPTH_LOG2.
- Pop detect:
  - rd_toggle passes through a 3-flop chain s1→s2→s3.
  - A pop is requested when s2 != s3.
- Pop when not empty:
  - Head entry goes to rd_data; rd_valid = 1.
  - The read pointer increments modulo 2^DEPTH_LOG2.
- Pop when empty:
  - rd_valid = 0; rd_data and rd_stamp hold.
  - Pointers are unchanged.
- Full, push only: the sample is dropped, overflow_count increments (saturating), and FIFO contents are unchanged.
- Full, push and pop in the same cycle: the pop executes and the push is accepted; level stays at full and overflow_count is unchanged.
- Empty, push and pop in the same cycle: the pop sees empty (rd_valid = 0) and the push is accepted; level becomes 1.
- Level arithmetic: level += push_accepted − pop_accepted, as an explicit (DEPTH_LOG2+1)-bit counter, not derived from the pointers.
- Reset (including mid-operation):
  - Pointers, level, overflow_count, rd_data, rd_valid and rd_stamp go to 0.
  - The s1..s3 chain loads the current rd_toggle value, so reset itself never creates a pop.
  - tp_prev loads tp_count, so reset never creates a push.
- Storage: inferred block RAM or distributed RAM with a synchronous write. The read may be asynchronous, or synchronous with a one-cycle output register, provided the Timing latencies below are met.

## Timing
- Push: a tp_count increment visible before edge E is stored at E. level, empty and full update after E.
- Pop: if rd_toggle changes before edge E0, s1 captures it at E0 and s2 at E1. rd_data, rd_valid, rd_stamp and level update at E2 (third edge). The host must wait at least 4 clki cycles (40 ns) before reading; wire-out polling latency covers this.
- Maximum sustained pop rate: one pop per rd_toggle change, at most one change per 2 cycles.
- No handshake back to the wake-up counter: the logger never stalls upstream.

## Configuration
- WU_LOG_TIMESTAMP_EN defined:
  - A 32-bit free-running cycle counter, cleared by reset and wrapping at 2^32, is stored alongside each sample. The FIFO word is JW+32 bits.
  - rd_stamp presents the stamp of the popped entry.
- WU_LOG_TIMESTAMP_EN undefined: no counter and no extra storage; rd_stamp is tied to 0.

## Test plan
- Reset: hold reset for 2 cycles with arbitrary inputs. Required: level = 0, empty = 1, full = 0, overflow_count = 0, rd_valid = 0, rd_data = 0. Toggling rd_toggle during reset causes no pop after release.
- Basic ordering: step tp_count 0→1→2→3 with jitter_in = 32'h10, 32'h20, 32'h30, then toggle rd_toggle 3 times. Required: rd_data = 32'h10, 32'h20, 32'h30, each with rd_valid = 1, each on the third edge after its toggle; level goes 3→0.
- Overflow: push 258 samples with no pops. Required: full = 1, level = 256, overflow_count = 2. A subsequent first pop returns sample #1, not #257.
- Empty pop: with the FIFO empty and rd_data = 32'h30, toggle once. Required: rd_valid = 0, rd_data stays 32'h30, level stays 0.
- Simultaneous operations and upstream reset:
  - At full, issue a push and a pop in the same cycle. Required: level stays 256, overflow_count unchanged.
  - Then step tp_count 5→0. Required: no push.
  - Then step tp_count 0→3 in one cycle. Required: exactly one push.
- With WU_LOG_TIMESTAMP_EN: push at cycles 100 and 150 after reset. Required: the two pops return rd_stamp values differing by exactly 50. Without the macro, rd_stamp = 0 throughout.
